inst_sram_axi_bridge: RTL

Responder for the pipeline's SRAM-style instruction-fetch port: accepts `inst_sram_en`/`inst_sram_addr` from the first fetch stage and turns each request into a single-beat AXI4 read. The returned word is presented on `inst_sram_rdata`. While a fetch is outstanding the block requests a pipeline stall. On `flush` it drops the in-flight fetch, draining any outstanding AXI beat. It sits between the fetch stages and the AXI interconnect.

---
 rtl/inst_sram_axi_bridge.sv | 117 +++++++++++
 1 files changed

// File: rtl/inst_sram_axi_bridge.sv
// Bridges the SRAM-style instruction-fetch port onto single-beat AXI4 reads.
// Only one read is outstanding at a time. A flush drains any beat still owed by the interconnect.
module inst_sram_axi_bridge #(
   parameter int               ID_WD  = 4,
   parameter logic [ID_WD-1:0] AXI_ID = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             inst_sram_en,
   input  logic [3:0]       inst_sram_we,
   input  logic [31:0]      inst_sram_addr,
   input  logic [31:0]      inst_sram_wdata,
   output logic [31:0]      inst_sram_rdata,
   output logic             stall_req,
   output logic             bus_err,
   output logic [ID_WD-1:0] arid,
   output logic [31:0]      araddr,
   output logic [7:0]       arlen,
   output logic [2:0]       arsize,
   output logic [1:0]       arburst,
   output logic             arvalid,
   input  logic             arready,
   input  logic [ID_WD-1:0] rid,
   input  logic [31:0]      rdata,
   input  logic [1:0]       rresp,
   input  logic             rlast,
   input  logic             rvalid,
   output logic             rready
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      AR    = 3'd1,
      R     = 3'd2,
      HOLD  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [29:0] addr_q, addr_d;
   logic [31:0] rdata_q, rdata_d;
   logic        kill_q, kill_d;
   logic        err_q, err_d;

   // Writes are fetched as plain reads; ID and last-beat flags carry no information here.
   logic unused_inputs;
   assign unused_inputs = ^{inst_sram_we, inst_sram_wdata, inst_sram_addr[1:0], rid, rlast};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rdata_q <= '0;
         kill_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         kill_q  <= kill_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
      kill_d  = kill_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (inst_sram_en && !flush) begin
               addr_d  = inst_sram_addr[31:2];
               state_d = AR;
            end
         end
         AR: begin
            // arvalid must stay up until accepted, so a flush here is remembered instead.
            if (flush) kill_d = 1'b1;
            if (arready) state_d = (flush || kill_q) ? DRAIN : R;
         end
         R: begin
            if (rvalid) begin
               if (flush || kill_q) begin
                  state_d = IDLE;
               end else begin
                  rdata_d = rdata;
                  err_d   = |rresp;
                  state_d = HOLD;
               end
            end else if (flush) begin
               state_d = DRAIN;
            end
         end
         HOLD: state_d = IDLE;
         DRAIN: begin
            if (rvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) kill_d = 1'b0;
   end

   assign arvalid         = (state_q == AR);
   assign rready          = (state_q == R) || (state_q == DRAIN);
   assign araddr          = {addr_q, 2'b00};
   assign arid            = AXI_ID;
   assign arlen           = 8'd0;
   assign arsize          = 3'b010;
   assign arburst         = 2'b01;
   assign inst_sram_rdata = rdata_q;
   assign bus_err         = err_q;
   assign stall_req       = inst_sram_en && (state_q != HOLD);

endmodule
